rvx_reset_sequencer: RTL and testbench



---
 rtl/rvx_reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_rvx_reset_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvx_reset_sequencer.sv
// Board-level reset/run controller for the rvx core: button debounce, reset hold-off,
// core clock-enable divider and a halt sequencing FSM.
module rvx_reset_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned CLOCK_DIVIDER   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  input  logic       halt_request,
  output logic       core_clock_enable,
  output logic       core_reset_n,
  output logic       core_halt,
  output logic [1:0] sequencer_state
);

  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DivW  = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLOCK_DIVIDER - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  localparam logic [1:0] StResetAsserted = 2'd0;
  localparam logic [1:0] StHold          = 2'd1;
  localparam logic [1:0] StRun           = 2'd2;
  localparam logic [1:0] StHalted        = 2'd3;

  logic             r_btn_meta;
  logic             r_btn_sync;
  logic             r_halt_meta;
  logic             r_halt_sync;
  logic             r_debounced;
  logic [DbW-1:0]   r_db_count;
  logic [DivW-1:0]  r_div_count;
  logic             r_cen;
  logic [1:0]       r_state;
  logic [HoldW-1:0] r_hold_count;
  logic             r_core_reset_n;
  logic             r_core_halt;

  logic [1:0]       w_state_next;
  logic [HoldW-1:0] w_hold_next;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_btn_meta  <= 1'b0;
      r_btn_sync  <= 1'b0;
      r_halt_meta <= 1'b0;
      r_halt_sync <= 1'b0;
    end else begin
      r_btn_meta  <= button;
      r_btn_sync  <= r_btn_meta;
      r_halt_meta <= halt_request;
      r_halt_sync <= r_halt_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_debounced <= 1'b0;
      r_db_count  <= '0;
    end else if (r_btn_sync == r_debounced) begin
      r_db_count <= '0;
    end else if (r_db_count == DbLast) begin
      r_debounced <= r_btn_sync;
      r_db_count  <= '0;
    end else begin
      r_db_count <= r_db_count + 1'b1;
    end
  end

  // Free-running divider; the strobe lands on the cycle after the counter's last value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_count <= '0;
      r_cen       <= 1'b0;
    end else begin
      r_cen <= (r_div_count == DivLast);
      if (r_div_count == DivLast) begin
        r_div_count <= '0;
      end else begin
        r_div_count <= r_div_count + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_count;
    case (r_state)
      StResetAsserted: begin
        w_hold_next = '0;
        if (!r_debounced) begin
          w_state_next = StHold;
        end
      end
      StHold: begin
        if (r_debounced) begin
          w_state_next = StResetAsserted;
        end else if (r_cen) begin
          if (r_hold_count == HoldLast) begin
            w_state_next = StRun;
          end else begin
            w_hold_next = r_hold_count + 1'b1;
          end
        end
      end
      StRun: begin
        if (r_debounced) begin
          w_state_next = StResetAsserted;
        end else if (r_halt_sync) begin
          w_state_next = StHalted;
        end
      end
      StHalted: begin
        if (r_debounced) begin
          w_state_next = StResetAsserted;
        end else if (!r_halt_sync) begin
          w_state_next = StRun;
        end
      end
      default: w_state_next = StResetAsserted;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= StResetAsserted;
      r_hold_count   <= '0;
      r_core_reset_n <= 1'b0;
      r_core_halt    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_hold_count   <= w_hold_next;
      r_core_reset_n <= (w_state_next == StRun) || (w_state_next == StHalted);
      r_core_halt    <= (w_state_next == StHalted);
    end
  end

  assign core_clock_enable = r_cen;
  assign core_reset_n      = r_core_reset_n;
  assign core_halt         = r_core_halt;
  assign sequencer_state   = r_state;

endmodule

// File: tb/tb_rvx_reset_sequencer.sv
// Randomized scoreboard bench for rvx_reset_sequencer, run with divider 2 and divider 1
// instances side by side on shared inputs.
module tb_rvx_reset_sequencer;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Hold = 3;

  typedef struct packed {
    bit       cen;
    bit       rst_n;
    bit       halt;
    bit [1:0] state;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       button;
  logic       halt_request;
  logic       cen0, rstn0, halt0;
  logic [1:0] st0;
  logic       cen1, rstn1, halt1;
  logic [1:0] st1;

  int checks   = 0;
  int failures = 0;

  rvx_reset_sequencer #(
    .DEBOUNCE_CYCLES(Deb),
    .HOLD_CYCLES    (Hold),
    .CLOCK_DIVIDER  (2)
  ) dut0 (
    .clock            (clock),
    .reset            (reset),
    .button           (button),
    .halt_request     (halt_request),
    .core_clock_enable(cen0),
    .core_reset_n     (rstn0),
    .core_halt        (halt0),
    .sequencer_state  (st0)
  );

  rvx_reset_sequencer #(
    .DEBOUNCE_CYCLES(Deb),
    .HOLD_CYCLES    (Hold),
    .CLOCK_DIVIDER  (1)
  ) dut1 (
    .clock            (clock),
    .reset            (reset),
    .button           (button),
    .halt_request     (halt_request),
    .core_clock_enable(cen1),
    .core_reset_n     (rstn1),
    .core_halt        (halt1),
    .sequencer_state  (st1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: edges counted since reset, input histories, and per-instance state
  // (0 reset, 1 hold, 2 run, 3 halted) following the behavioural rules directly.
  int   divs[2] = '{2, 1};
  int   n_edge[2];
  bit   deb[2];
  int   streak[2];
  int   st[2];
  int   strobes[2];
  bit   btn_hist[$];
  bit   halt_hist[$];
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  function automatic void model_init();
    for (int i = 0; i < 2; i++) begin
      n_edge[i]  = 0;
      deb[i]     = 1'b0;
      streak[i]  = 0;
      st[i]      = 0;
      strobes[i] = 0;
    end
    btn_hist.delete();
    halt_hist.delete();
    exp_q0.delete();
    exp_q1.delete();
  endfunction

  function automatic exp_t model_step(input int i, input bit bs, input bit hs);
    exp_t e;
    bit   deb_old;
    bit   cen_old;
    deb_old = deb[i];
    cen_old = (n_edge[i] >= 1) && ((n_edge[i] % divs[i]) == 0);
    n_edge[i]++;
    case (st[i])
      0: if (!deb_old) begin st[i] = 1; strobes[i] = 0; end
      1: begin
        if (deb_old) st[i] = 0;
        else if (cen_old) begin
          strobes[i]++;
          if (strobes[i] == Hold) st[i] = 2;
        end
      end
      2: if (deb_old) st[i] = 0; else if (hs) st[i] = 3;
      default: if (deb_old) st[i] = 0; else if (!hs) st[i] = 2;
    endcase
    // Debounced value follows after Deb consecutive differing cycles.
    if (bs != deb[i]) begin
      streak[i]++;
      if (streak[i] == Deb) begin
        deb[i]    = bs;
        streak[i] = 0;
      end
    end else begin
      streak[i] = 0;
    end
    e.cen   = (n_edge[i] % divs[i]) == 0;
    e.rst_n = st[i] >= 2;
    e.halt  = st[i] == 3;
    e.state = 2'(st[i]);
    return e;
  endfunction

  initial begin
    bit bs, hs;
    model_init();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        model_init();
      end else begin
        // The synchronized value seen at this edge was sampled two edges earlier.
        bs = (btn_hist.size() >= 2) ? btn_hist[btn_hist.size()-2] : 1'b0;
        hs = (halt_hist.size() >= 2) ? halt_hist[halt_hist.size()-2] : 1'b0;
        btn_hist.push_back(button);
        halt_hist.push_back(halt_request);
        if (btn_hist.size() > 4) void'(btn_hist.pop_front());
        if (halt_hist.size() > 4) void'(halt_hist.pop_front());
        exp_q0.push_back(model_step(0, bs, hs));
        exp_q1.push_back(model_step(1, bs, hs));
      end
    end
  end

  // Monitor: outputs are presented every edge once out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
          chk("scoreboard_underflow", 0, 1);
        end else begin
          e = exp_q0.pop_front();
          chk("div2_enable", int'(cen0), int'(e.cen));
          chk("div2_reset_n", int'(rstn0), int'(e.rst_n));
          chk("div2_halt", int'(halt0), int'(e.halt));
          chk("div2_state", int'(st0), int'(e.state));
          e = exp_q1.pop_front();
          chk("div1_enable", int'(cen1), int'(e.cen));
          chk("div1_reset_n", int'(rstn1), int'(e.rst_n));
          chk("div1_halt", int'(halt1), int'(e.halt));
          chk("div1_state", int'(st1), int'(e.state));
        end
      end
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_enable"}, int'({cen0, cen1}), 0);
    chk({name, "_reset_n"}, int'({rstn0, rstn1}), 0);
    chk({name, "_halt"}, int'({halt0, halt1}), 0);
    chk({name, "_state"}, int'({st0, st1}), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int kind;
    button       = 1'b0;
    halt_request = 1'b0;
    reset        = 1'b1;
    idle(3);
    chk_zero("reset_hold");
    reset = 1'b0;
    idle(30);
    for (int p = 0; p < 80; p++) begin
      kind = int'($urandom_range(0, 6));
      case (kind)
        0: begin
          halt_request = 1'($urandom_range(0, 1));
          idle(int'($urandom_range(10, 40)));
        end
        1: begin
          button = 1'b1;
          idle(int'($urandom_range(1, 3)));
          button = 1'b0;
          idle(10);
        end
        2: begin
          button = 1'b1;
          idle(int'($urandom_range(5, 12)));
          button = 1'b0;
          idle(int'($urandom_range(20, 40)));
        end
        3: begin
          halt_request = 1'b1;
          idle(int'($urandom_range(4, 20)));
          halt_request = 1'b0;
          idle(8);
        end
        4: begin
          button       = 1'b1;
          halt_request = 1'b1;
          idle(8);
          button = 1'b0;
          idle(25);
          halt_request = 1'b0;
          idle(8);
        end
        5: begin
          idle(int'($urandom_range(0, 15)));
          #2 reset = 1'b1;
          #1 chk_zero("async_reset");
          idle(1);
          reset = 1'b0;
          idle(20);
        end
        default: begin
          for (int k = 0; k < 8; k++) begin
            button       = 1'($urandom_range(0, 1));
            halt_request = 1'($urandom_range(0, 1));
            idle(1);
          end
          button = 1'b0;
          idle(20);
        end
      endcase
    end
    idle(2);
    chk("scoreboard_drain", exp_q0.size() + exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
